// File: rtl/mips_alu_32b_pkg.sv
// Shared constants for the MIPS 32-bit ALU: control codes, alu_op encodings and R-type funct values.
// Optional feature macro used elsewhere in this slice: ALU_CARRYOUT_EN.
package mips_alu_32b_pkg;

  typedef enum logic [3:0] {
    CTRL_AND     = 4'b0000,
    CTRL_OR      = 4'b0001,
    CTRL_ADD     = 4'b0010,
    CTRL_SUB     = 4'b0110,
    CTRL_SLT     = 4'b0111,
    CTRL_NOR     = 4'b1100,
    CTRL_INVALID = 4'b1111
  } alu_ctrl_e;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_ADD2 = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/mips_alu_32b_if.sv
// Operand/result bundle between an instruction pipeline (master) and the ALU (slave).
// carryout exists only when ALU_CARRYOUT_EN is defined.
interface mips_alu_32b_if;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic        out_valid;
`ifdef ALU_CARRYOUT_EN
  logic        carryout;
`endif

  modport master (
    output in_valid, alu_op, funct, a, b,
    input  alu_ctrl, result, overflow, zero, out_valid
`ifdef ALU_CARRYOUT_EN
    , input carryout
`endif
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b,
    output alu_ctrl, result, overflow, zero, out_valid
`ifdef ALU_CARRYOUT_EN
    , output carryout
`endif
  );
endinterface

// File: rtl/mips_alu_ctrl_dec.sv
// Combinational ALU control decode from alu_op and the R-type funct field.
module mips_alu_ctrl_dec
  import mips_alu_32b_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctrl
);

  always_comb begin
    ctrl = CTRL_INVALID;
    case (alu_op)
      ALUOP_ADD, ALUOP_ADD2: ctrl = CTRL_ADD;
      ALUOP_SUB:             ctrl = CTRL_SUB;
      default: begin
        case (funct)
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_NOR: ctrl = CTRL_NOR;
          FUNCT_SLT: ctrl = CTRL_SLT;
          default:   ctrl = CTRL_INVALID;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_alu_32b.sv
// MIPS 32-bit ALU with one registered output stage; decode lives in mips_alu_ctrl_dec.
// Optional carryout output enabled by ALU_CARRYOUT_EN.
module mips_alu_32b
  import mips_alu_32b_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  mips_alu_32b_if.slave bus
);

  logic [3:0]  ctrl_next;
  logic [32:0] sum_ext;
  logic [32:0] diff_ext;
  logic        add_ovf;
  logic        sub_ovf;
  logic        slt_bit;
  logic [31:0] result_next;
  logic        overflow_next;

  logic [3:0]  alu_ctrl_reg;
  logic [31:0] result_reg;
  logic        overflow_reg;
  logic        zero_reg;
  logic        out_valid_reg;

  mips_alu_ctrl_dec u_dec (
    .alu_op (bus.alu_op),
    .funct  (bus.funct),
    .ctrl   (ctrl_next)
  );

  // Subtraction as a + ~b + 1 so bit 32 is directly the NOT-borrow flag.
  // Overflow = carry into bit 31 XOR carry out of bit 31.
  assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + 33'd1;
  assign add_ovf  = (bus.a[31] ^ bus.b[31] ^ sum_ext[31]) ^ sum_ext[32];
  assign sub_ovf  = (bus.a[31] ^ ~bus.b[31] ^ diff_ext[31]) ^ diff_ext[32];
  assign slt_bit  = diff_ext[31] ^ sub_ovf;

  always_comb begin
    result_next   = 32'd0;
    overflow_next = 1'b0;
    case (ctrl_next)
      CTRL_AND: result_next = bus.a & bus.b;
      CTRL_OR:  result_next = bus.a | bus.b;
      CTRL_NOR: result_next = ~(bus.a | bus.b);
      CTRL_ADD: begin
        result_next   = sum_ext[31:0];
        overflow_next = add_ovf;
      end
      CTRL_SUB: begin
        result_next   = diff_ext[31:0];
        overflow_next = sub_ovf;
      end
      CTRL_SLT: result_next = {31'd0, slt_bit};
      default:  result_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl_reg  <= 4'd0;
      result_reg    <= 32'd0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        alu_ctrl_reg <= ctrl_next;
        result_reg   <= result_next;
        overflow_reg <= overflow_next;
        zero_reg     <= (result_next == 32'd0);
      end
    end
  end

  assign bus.alu_ctrl  = alu_ctrl_reg;
  assign bus.result    = result_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.zero      = zero_reg;
  assign bus.out_valid = out_valid_reg;

`ifdef ALU_CARRYOUT_EN
  logic carryout_next;
  logic carryout_reg;

  always_comb begin
    carryout_next = 1'b0;
    if (ctrl_next == CTRL_ADD)      carryout_next = sum_ext[32];
    else if (ctrl_next == CTRL_SUB) carryout_next = diff_ext[32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            carryout_reg <= 1'b0;
    else if (bus.in_valid) carryout_reg <= carryout_next;
  end

  assign bus.carryout = carryout_reg;
`endif

endmodule

// File: tb/tb_mips_alu_32b.sv
// Directed self-checking bench for mips_alu_32b (define ALU_CARRYOUT_EN to also cover carryout).
module tb_mips_alu_32b;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  mips_alu_32b_if bus ();

  mips_alu_32b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.funct    = f;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.alu_op = 2'b00; bus.funct = 6'd0;
    bus.a = 32'd7; bus.b = 32'd9;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.result !== 32'd0) $display("FAIL reset_result got=%h exp=0", bus.result); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.zero !== 1'b0) $display("FAIL reset_zero got=%b exp=0", bus.zero); else pass_cnt++;
    total_cnt++; if (bus.alu_ctrl !== 4'd0 || bus.overflow !== 1'b0)
      $display("FAIL reset_ctrl_ovf got=%b/%b exp=0000/0", bus.alu_ctrl, bus.overflow); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_add;
    apply(1'b1, 2'b00, 6'd0, 32'd5, 32'hFFFF_FFFE);
    $display("txn add a=5 b=fffffffe -> result=%h ctrl=%b ovf=%b zero=%b ov=%b",
             bus.result, bus.alu_ctrl, bus.overflow, bus.zero, bus.out_valid);
    total_cnt++; if (bus.result !== 32'd3) $display("FAIL add_result got=%h exp=%h", bus.result, 32'd3); else pass_cnt++;
    total_cnt++; if (bus.alu_ctrl !== 4'b0010) $display("FAIL add_ctrl got=%b exp=0010", bus.alu_ctrl); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0 || bus.zero !== 1'b0)
      $display("FAIL add_flags got=ovf%b zero%b exp=ovf0 zero0", bus.overflow, bus.zero); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL add_out_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_sub;
    apply(1'b1, 2'b01, 6'd0, 32'h1234_5678, 32'h1234_5678);
    $display("txn sub equal -> result=%h zero=%b ctrl=%b ovf=%b", bus.result, bus.zero, bus.alu_ctrl, bus.overflow);
    total_cnt++; if (bus.result !== 32'd0 || bus.zero !== 1'b1)
      $display("FAIL sub_eq got=%h/zero%b exp=0/zero1", bus.result, bus.zero); else pass_cnt++;
    total_cnt++; if (bus.alu_ctrl !== 4'b0110 || bus.overflow !== 1'b0)
      $display("FAIL sub_eq_ctrl got=%b/%b exp=0110/0", bus.alu_ctrl, bus.overflow); else pass_cnt++;
    apply(1'b1, 2'b01, 6'd0, 32'h8000_0000, 32'd1);
    $display("txn sub 80000000-1 -> result=%h ovf=%b", bus.result, bus.overflow);
    total_cnt++; if (bus.result !== 32'h7FFF_FFFF || bus.overflow !== 1'b1)
      $display("FAIL sub_ovf got=%h/%b exp=7fffffff/1", bus.result, bus.overflow); else pass_cnt++;
  endtask

  task automatic test_rtype;
    apply(1'b1, 2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1);
    $display("txn radd 7fffffff+1 -> result=%h ovf=%b", bus.result, bus.overflow);
    total_cnt++; if (bus.result !== 32'h8000_0000 || bus.overflow !== 1'b1)
      $display("FAIL radd_ovf got=%h/%b exp=80000000/1", bus.result, bus.overflow); else pass_cnt++;
    apply(1'b1, 2'b10, 6'b101010, 32'h7FFF_FFFF, 32'd1);
    $display("txn slt 7fffffff<1 -> result=%h", bus.result);
    total_cnt++; if (bus.result !== 32'd0 || bus.zero !== 1'b1 || bus.alu_ctrl !== 4'b0111)
      $display("FAIL slt_false got=%h/z%b/%b exp=0/z1/0111", bus.result, bus.zero, bus.alu_ctrl); else pass_cnt++;
    apply(1'b1, 2'b10, 6'b101010, 32'h8000_0000, 32'd1);
    $display("txn slt 80000000<1 -> result=%h ovf=%b", bus.result, bus.overflow);
    total_cnt++; if (bus.result !== 32'd1 || bus.overflow !== 1'b0)
      $display("FAIL slt_ovfcorr got=%h/%b exp=1/0", bus.result, bus.overflow); else pass_cnt++;
    apply(1'b1, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    $display("txn slt -1<1 -> result=%h", bus.result);
    total_cnt++; if (bus.result !== 32'd1) $display("FAIL slt_neg got=%h exp=1", bus.result); else pass_cnt++;
    apply(1'b1, 2'b10, 6'b100111, 32'd0, 32'd0);
    $display("txn nor 0,0 -> result=%h ctrl=%b", bus.result, bus.alu_ctrl);
    total_cnt++; if (bus.result !== 32'hFFFF_FFFF || bus.alu_ctrl !== 4'b1100)
      $display("FAIL nor_zero got=%h/%b exp=ffffffff/1100", bus.result, bus.alu_ctrl); else pass_cnt++;
    apply(1'b1, 2'b10, 6'b100010, 32'd3, 32'd10);
    $display("txn rsub 3-10 -> result=%h", bus.result);
    total_cnt++; if (bus.result !== 32'hFFFF_FFF9 || bus.overflow !== 1'b0)
      $display("FAIL rsub got=%h/%b exp=fffffff9/0", bus.result, bus.overflow); else pass_cnt++;
  endtask

  task automatic test_invalid_hold;
    apply(1'b1, 2'b10, 6'b000000, 32'h1111_2222, 32'h3333_4444);
    $display("txn invalid funct -> ctrl=%b result=%h zero=%b", bus.alu_ctrl, bus.result, bus.zero);
    total_cnt++; if (bus.alu_ctrl !== 4'b1111 || bus.result !== 32'd0 || bus.zero !== 1'b1)
      $display("FAIL invalid got=%b/%h/z%b exp=1111/0/z1", bus.alu_ctrl, bus.result, bus.zero); else pass_cnt++;
    apply(1'b0, 2'b00, 6'd0, 32'd5, 32'd6);
    $display("txn idle -> out_valid=%b ctrl=%b result=%h zero=%b", bus.out_valid, bus.alu_ctrl, bus.result, bus.zero);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL idle_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.alu_ctrl !== 4'b1111 || bus.result !== 32'd0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0)
      $display("FAIL idle_hold got=%b/%h/z%b/o%b exp=1111/0/z1/o0", bus.alu_ctrl, bus.result, bus.zero, bus.overflow); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ops  [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
    logic [5:0]  fns  [5] = '{6'b100100, 6'b100101, 6'b100111, 6'b000000, 6'b111111};
    logic [31:0] as   [5] = '{32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'd10, 32'd1};
    logic [31:0] bs   [5] = '{32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'd3, 32'd2};
    logic [31:0] exps [5] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'h000F_F000, 32'd7, 32'd3};
    logic [3:0]  ctls [5] = '{4'b0000, 4'b0001, 4'b1100, 4'b0110, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, ops[i], fns[i], as[i], bs[i]);
      $display("txn b2b[%0d] -> result=%h ctrl=%b ov=%b", i, bus.result, bus.alu_ctrl, bus.out_valid);
      total_cnt++;
      if (bus.result !== exps[i] || bus.alu_ctrl !== ctls[i] || bus.out_valid !== 1'b1)
        $display("FAIL b2b_%0d got=%h/%b/v%b exp=%h/%b/v1", i, bus.result, bus.alu_ctrl, bus.out_valid, exps[i], ctls[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream;
    apply(1'b1, 2'b00, 6'd0, 32'd100, 32'd23);
    total_cnt++; if (bus.result !== 32'd123 || bus.out_valid !== 1'b1)
      $display("FAIL pre_rst got=%h/v%b exp=7b/v1", bus.result, bus.out_valid); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    $display("txn async reset mid-stream -> result=%h ov=%b zero=%b ctrl=%b", bus.result, bus.out_valid, bus.zero, bus.alu_ctrl);
    total_cnt++; if (bus.result !== 32'd0 || bus.out_valid !== 1'b0 || bus.zero !== 1'b0 || bus.alu_ctrl !== 4'd0)
      $display("FAIL midrst got=%h/v%b/z%b/%b exp=0/v0/z0/0000", bus.result, bus.out_valid, bus.zero, bus.alu_ctrl); else pass_cnt++;
    #1 rst_n = 1'b1;
    apply(1'b1, 2'b01, 6'd0, 32'd50, 32'd8);
    $display("txn after reset sub 50-8 -> result=%h ov=%b", bus.result, bus.out_valid);
    total_cnt++; if (bus.result !== 32'd42 || bus.out_valid !== 1'b1)
      $display("FAIL post_rst got=%h/v%b exp=2a/v1", bus.result, bus.out_valid); else pass_cnt++;
  endtask

`ifdef ALU_CARRYOUT_EN
  task automatic test_carryout;
    apply(1'b1, 2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1);
    $display("txn carry add -> result=%h carryout=%b", bus.result, bus.carryout);
    total_cnt++; if (bus.carryout !== 1'b1 || bus.result !== 32'd0)
      $display("FAIL co_add got=%b/%h exp=1/0", bus.carryout, bus.result); else pass_cnt++;
    apply(1'b1, 2'b01, 6'd0, 32'd3, 32'd5);
    total_cnt++; if (bus.carryout !== 1'b0) $display("FAIL co_sub_borrow got=%b exp=0", bus.carryout); else pass_cnt++;
    apply(1'b1, 2'b01, 6'd0, 32'd5, 32'd3);
    total_cnt++; if (bus.carryout !== 1'b1) $display("FAIL co_sub_noborrow got=%b exp=1", bus.carryout); else pass_cnt++;
    apply(1'b1, 2'b10, 6'b100101, 32'hFFFF_FFFF, 32'd1);
    total_cnt++; if (bus.carryout !== 1'b0) $display("FAIL co_or got=%b exp=0", bus.carryout); else pass_cnt++;
    apply(1'b0, 2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1);
    total_cnt++; if (bus.carryout !== 1'b0) $display("FAIL co_hold got=%b exp=0", bus.carryout); else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_add();
    test_sub();
    test_rtype();
    test_invalid_hold();
    test_back_to_back();
    test_reset_midstream();
`ifdef ALU_CARRYOUT_EN
    test_carryout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
